// File: rtl/regfile_pkg.sv
// Shared definitions for the handshake register file: command bit positions
// and the request-handling state encoding.
package regfile_pkg;

    // Bit positions inside the 3-bit command mask
    localparam int INSTR_RD1 = 2;
    localparam int INSTR_RD2 = 1;
    localparam int INSTR_WR  = 0;

    // Request handling state: IDLE accepts, BUSY counts down to commit
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A command with no bits set is a no-op that never commits
    function automatic logic instr_has_op(input logic [2:0] instr);
        return (instr != 3'b000);
    endfunction

endpackage

// File: rtl/regfile_array.sv
// Two-read / one-write storage array with combinational reads and an
// asynchronous clear. With ZERO_REG set, entry 0 is hardwired to zero.
module regfile_array #(
    parameter  int DW       = 16,
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem_q [DEPTH];
    logic          wr_blocked_s;

    assign wr_blocked_s = (ZERO_REG != 0) && (waddr == '0);

    // Storage: cleared by reset; writes to a hardwired-zero entry are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && !wr_blocked_s) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read ports; entry 0 forced to zero when hardwired
    always_comb begin
        rdata1 = mem_q[raddr1];
        rdata2 = mem_q[raddr2];
        if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else begin
            rdata1 = mem_q[raddr1];
        end
        if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end else begin
            rdata2 = mem_q[raddr2];
        end
    end

endmodule

// File: rtl/regfile_hs.sv
// Multi-cycle register file with a valid/ready request handshake.
// A request is captured on acceptance and committed LAT edges later (the
// accept edge counts as edge 1). At commit the selected read ports sample
// the array before the write lands, so a same-op read sees the old value.
module regfile_hs
    import regfile_pkg::*;
#(
    parameter  int DW       = 16,
    parameter  int DEPTH    = 32,
    parameter  int LAT      = 3,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    instr,
    input  logic [AW-1:0] read1,
    input  logic [AW-1:0] read2,
    input  logic [AW-1:0] write,
    input  logic [DW-1:0] writed,
    output logic [DW-1:0] readd1,
    output logic [DW-1:0] readd2,
    output logic          done
);

    localparam int            CW       = $clog2(LAT) + 1;
    // Countdown loaded at acceptance so that commit happens on edge LAT
    localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 1) ? (LAT - 2) : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0]    instr_q;
    logic [AW-1:0] rd1_addr_q, rd2_addr_q, wr_addr_q;
    logic [DW-1:0] wr_data_q;

    logic [DW-1:0] readd1_q, readd2_q;
    logic          done_q;

    logic          accept_s, commit_s;
    logic [2:0]    op_instr_s;
    logic [AW-1:0] op_rd1_s, op_rd2_s, op_wr_s;
    logic [DW-1:0] op_wd_s;
    logic [DW-1:0] rdata1_s, rdata2_s;
    logic          we_s;

    assign req_ready = (state_q == IDLE);

    // Handshake FSM and latency countdown: decides accept and commit edges
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && instr_has_op(instr)) begin
                    accept_s = 1'b1;
                    if (LAT == 1) begin
                        commit_s = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    commit_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture so later input changes cannot affect an in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= 3'b000;
            rd1_addr_q <= '0;
            rd2_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (accept_s) begin
            instr_q    <= instr;
            rd1_addr_q <= read1;
            rd2_addr_q <= read2;
            wr_addr_q  <= write;
            wr_data_q  <= writed;
        end
    end

    // With single-edge latency the commit uses the live request directly
    always_comb begin
        op_instr_s = instr_q;
        op_rd1_s   = rd1_addr_q;
        op_rd2_s   = rd2_addr_q;
        op_wr_s    = wr_addr_q;
        op_wd_s    = wr_data_q;
        if (LAT == 1) begin
            op_instr_s = instr;
            op_rd1_s   = read1;
            op_rd2_s   = read2;
            op_wr_s    = write;
            op_wd_s    = writed;
        end else begin
            op_instr_s = instr_q;
        end
    end

    assign we_s = commit_s && op_instr_s[INSTR_WR];

    regfile_array #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_s),
        .waddr  (op_wr_s),
        .wdata  (op_wd_s),
        .raddr1 (op_rd1_s),
        .raddr2 (op_rd2_s),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s)
    );

    // Output registers: selected ports load at commit, done flags the commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readd1_q <= '0;
            readd2_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= commit_s;
            if (commit_s && op_instr_s[INSTR_RD1]) begin
                readd1_q <= rdata1_s;
            end
            if (commit_s && op_instr_s[INSTR_RD2]) begin
                readd2_q <= rdata2_s;
            end
        end
    end

    assign readd1 = readd1_q;
    assign readd2 = readd2_q;
    assign done   = done_q;

endmodule

// File: tb/tb_regfile_hs.sv
// Scoreboard bench for regfile_hs. Instance 0: LAT=3, no zero register.
// Instance 1: LAT=1, register 0 hardwired to zero. A reference model built
// from plain arrays predicts each committed op's read results when the op is
// issued; a monitor pops and compares on every done pulse.
module tb_regfile_hs;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NI    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_valid [NI];
    logic          req_ready [NI];
    logic [2:0]    instr     [NI];
    logic [AW-1:0] read1     [NI];
    logic [AW-1:0] read2     [NI];
    logic [AW-1:0] wr        [NI];
    logic [DW-1:0] writed    [NI];
    logic [DW-1:0] readd1    [NI];
    logic [DW-1:0] readd2    [NI];
    logic          done      [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            regfile_hs #(
                .DW       (DW),
                .DEPTH    (DEPTH),
                .LAT      ((g == 0) ? 3 : 1),
                .ZERO_REG (g)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid[g]),
                .req_ready (req_ready[g]),
                .instr     (instr[g]),
                .read1     (read1[g]),
                .read2     (read2[g]),
                .write     (wr[g]),
                .writed    (writed[g]),
                .readd1    (readd1[g]),
                .readd2    (readd2[g]),
                .done      (done[g])
            );
        end
    endgenerate

    // Reference model state
    logic [DW-1:0] mdl_mem [NI][DEPTH];
    logic [DW-1:0] mdl_r1  [NI];
    logic [DW-1:0] mdl_r2  [NI];

    typedef struct packed {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt [NI];
    int run_len  [NI];
    int max_run  [NI];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input int k, input logic [AW-1:0] a);
        if (k == 1 && a == 5'd0) return 16'h0000;
        return mdl_mem[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[k][i] = 16'h0000;
            mdl_r1[k] = 16'h0000;
            mdl_r2[k] = 16'h0000;
        end
        q0.delete();
        q1.delete();
    endtask

    // Whole-op semantics: reads observe state before this op's write
    task automatic model_apply(input int k, input logic [2:0] ins, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd);
        exp_t e;
        if (ins == 3'b000) return;
        if (ins[2]) mdl_r1[k] = mread(k, a1);
        if (ins[1]) mdl_r2[k] = mread(k, a2);
        if (ins[0] && !(k == 1 && wa == 5'd0)) mdl_mem[k][wa] = wd;
        e.r1 = mdl_r1[k];
        e.r2 = mdl_r2[k];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic issue(input int k, input logic [2:0] ins, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input bit hold);
        int guard = 0;
        while (req_ready[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait dut%0d: req_ready=%b, expected 1 within 50 cycles", k, req_ready[k]);
        end
        instr[k]     = ins;
        read1[k]     = a1;
        read2[k]     = a2;
        wr[k]        = wa;
        writed[k]    = wd;
        req_valid[k] = 1'b1;
        model_apply(k, ins, a1, a2, wa, wd);
        @(posedge clk);
        #1;
        if (!hold) req_valid[k] = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: pending %0d/%0d, expected 0/0", q0.size(), q1.size());
        end
        @(negedge clk);
    endtask

    // Monitor: every done pulse consumes one predicted result
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (rst_n === 1'b1 && done[k] === 1'b1) begin
                done_cnt[k]++;
                run_len[k]++;
                if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done dut%0d: done=1, expected 0 (nothing pending)", k);
                end else begin
                    if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                    chk($sformatf("readd1_dut%0d", k), 32'(readd1[k]), 32'(e.r1));
                    chk($sformatf("readd2_dut%0d", k), 32'(readd2[k]), 32'(e.r2));
                end
            end else begin
                run_len[k] = 0;
            end
        end
    end

    logic [AW-1:0] t6_addr [4];
    logic [DW-1:0] t6_data [4];
    int base;

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            instr[k]     = 3'b000;
            read1[k]     = 5'd0;
            read2[k]     = 5'd0;
            wr[k]        = 5'd0;
            writed[k]    = 16'h0000;
            done_cnt[k]  = 0;
            run_len[k]   = 0;
            max_run[k]   = 0;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ready_dut%0d", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("rst_done_dut%0d", k), 32'(done[k]), 32'd0);
            chk($sformatf("rst_readd1_dut%0d", k), 32'(readd1[k]), 32'd0);
            chk($sformatf("rst_readd2_dut%0d", k), 32'(readd2[k]), 32'd0);
        end

        // Reset in the middle of a busy write aborts it
        instr[0] = 3'b001; wr[0] = 5'd5; writed[0] = 16'hBEEF; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        chk("midop_busy_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midop_ready_after_reset", 32'(req_ready[0]), 32'd1);
        issue(0, 3'b100, 5'd5, 5'd0, 5'd0, 16'h0000, 1'b0);
        wait_drain();

        // LAT=3 timing: ready low two cycles, done after the third edge
        issue(0, 3'b001, 5'd0, 5'd0, 5'd7, 16'h1234, 1'b0);
        chk("lat3_ready_c1", 32'(req_ready[0]), 32'd0);
        chk("lat3_done_c1", 32'(done[0]), 32'd0);
        @(posedge clk); #1;
        chk("lat3_ready_c2", 32'(req_ready[0]), 32'd0);
        chk("lat3_done_c2", 32'(done[0]), 32'd0);
        @(posedge clk); #1;
        chk("lat3_ready_done_cycle", 32'(req_ready[0]), 32'd1);
        chk("lat3_done_pulse", 32'(done[0]), 32'd1);
        @(posedge clk); #1;
        chk("lat3_done_cleared", 32'(done[0]), 32'd0);
        issue(0, 3'b100, 5'd7, 5'd0, 5'd0, 16'h0000, 1'b0);

        // Same-op read of the write address sees the old value
        issue(0, 3'b001, 5'd0, 5'd0, 5'd3, 16'h00AA, 1'b0);
        issue(0, 3'b101, 5'd3, 5'd0, 5'd3, 16'h0055, 1'b0);
        issue(0, 3'b110, 5'd3, 5'd3, 5'd0, 16'h0000, 1'b0);
        wait_drain();

        // No-op request: accepted, no done, outputs untouched
        base = done_cnt[0];
        issue(0, 3'b000, 5'd3, 5'd3, 5'd3, 16'hDEAD, 1'b0);
        chk("noop_ready", 32'(req_ready[0]), 32'd1);
        repeat (5) @(negedge clk);
        chk("noop_no_done", 32'(done_cnt[0] - base), 32'd0);
        chk("noop_readd1_held", 32'(readd1[0]), 32'(mdl_r1[0]));
        chk("noop_readd2_held", 32'(readd2[0]), 32'(mdl_r2[0]));

        // Hardwired zero register
        base = done_cnt[1];
        issue(1, 3'b001, 5'd0, 5'd0, 5'd0, 16'hFFFF, 1'b0);
        wait_drain();
        chk("zero_write_done", 32'(done_cnt[1] - base), 32'd1);
        issue(1, 3'b110, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b0);
        wait_drain();

        // LAT=1 back-to-back with valid held: 4 writes then 4 reads
        t6_addr[0] = 5'd31; t6_addr[1] = 5'd1; t6_addr[2] = 5'd2; t6_addr[3] = 5'd17;
        for (int i = 0; i < 4; i++) t6_data[i] = 16'($urandom);
        base = done_cnt[1];
        max_run[1] = 0;
        for (int i = 0; i < 4; i++)
            issue(1, 3'b001, 5'd0, 5'd0, t6_addr[i], t6_data[i], 1'b1);
        for (int i = 0; i < 4; i++)
            issue(1, 3'b110, t6_addr[i], t6_addr[(i + 1) % 4], 5'd0, 16'h0000, 1'b1);
        req_valid[1] = 1'b0;
        wait_drain();
        chk("lat1_done_count", 32'(done_cnt[1] - base), 32'd8);
        chk("lat1_done_continuous", 32'(max_run[1] >= 8), 32'd1);

        // Randomized traffic on both instances
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 40; n++) begin
                issue(k, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      16'($urandom), 1'($urandom_range(0, 1)));
            end
            req_valid[k] = 1'b0;
            wait_drain();
        end

        chk("final_q0_empty", 32'(q0.size()), 32'd0);
        chk("final_q1_empty", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
